wb_queue: RTL and testbench
===========================

# wb_queue

Writeback queue between the execution units and the `registers` block. It accepts completed results from the ALU and the load unit, holds them in order in a small circular buffer, and drains up to two per cycle onto the register file's `write0`/`write1` ports. It also exports a pending-register mask and two forwarding lookups so operand fetch can interlock or bypass results not yet written.

## Interface
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result offered.
- `alu_addr`  in  `WIDTH_SEG`  ALU destination register.
- `alu_data`  in  `WIDTH_WORD`  ALU result.
- `mem_valid`  in  1  load result offered.
- `mem_addr`  in  `WIDTH_SEG`  load destination register.
- `mem_data`  in  `WIDTH_WORD`  load data.
- `in_ready`  out  1  both producers may enqueue this cycle.
- `write0`, `waddr0`, `in0`  out  1 / `WIDTH_SEG` / `WIDTH_WORD`  register file write port 0 (oldest entry).
- `write1`, `waddr1`, `in1`  out  1 / `WIDTH_SEG` / `WIDTH_WORD`  register file write port 1 (second-oldest entry).
- `pending`  out  2**`WIDTH_SEG`  bit r set iff a valid entry targets register r.
- `fwd_addr0`, `fwd_addr1`  in  `WIDTH_SEG`  lookup addresses, paired with register file `raddr0`/`raddr1`.
- `fwd_hit0`, `fwd_hit1`  out  1  lookup matched a queued entry.
- `fwd_data0`, `fwd_data1`  out  `WIDTH_WORD`  data of the youngest matching entry.

## Operation
- State: `DEPTH` entries {addr, data}, head pointer, tail pointer, count (0..`DEPTH`).
- `in_ready` = (`DEPTH` − count ≥ 2), from registered count only; no credit for same-cycle drains.
- Enqueue happens on `valid && in_ready`. If both producers are valid, the ALU entry is written at tail and the load entry at tail+1, so the ALU entry is older. A single valid producer takes the tail slot.
- Valid with `in_ready`=0 is not accepted. The producer holds its values; they must remain stable until accepted.
- Drain (combinational from registered state):
  - `write0` = count ≥ 1, driven from the head entry.
  - `write1` = count ≥ 2 and entry[head+1].addr ≠ entry[head].addr, driven from head+1.
  - Same-address pair: only head drains that cycle, which preserves write order. The register file's port priority is never relied on.
- The pop count (0/1/2) equals `write0`+`write1`. Head advances by the pop count at the edge, the same edge at which the register file commits.
- Count update is count + pushes − pops. Pointers wrap modulo `DEPTH`.
- `pending` is the OR over valid entries of onehot(addr); entries draining this cycle are still included.
- Forwarding:
  - A hit requires a valid entry whose addr equals `fwd_addrN`; data comes from the youngest such entry.
  - Same-cycle inputs are not visible.
  - With no hit, `fwd_data` = 0.
- Register 0 gets no special treatment.

## Timing
- Reset (async assert, sync-safe deassert): count = 0, head = tail = 0, so `write0` = `write1` = 0, `in_ready` = 1, `pending` = 0, `fwd_hit*` = 0. Entry contents are don't-care. Reset mid-operation discards all queued results.
- Latency: a result accepted at edge N is presented on `write0` during cycle N+1 (if it is head) and is visible in `regs` after edge N+1.
- Throughput: 2 results/cycle sustained when there are no same-address pairs.
- Full (count ≥ `DEPTH`−1): `in_ready` = 0; draining continues.
- Empty: no write strobes; `pending` = 0.
- Simultaneous push and pop in the same cycle are both applied; count stays within 0..`DEPTH`.

## Structure
- Add `WB_DEPTH` (default 4) to `const.v` next to `WIDTH_SEG`/`WIDTH_WORD`.
- One sub-module, `wb_fwd_match`: given the entry array, valid mask and head, it returns hit and youngest-match data. It is instantiated twice, once per lookup port.
- The queue pointers, count and drain logic stay in `wb_queue`.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream with 3 entries queued → `write0` = `write1` = 0, `pending` = 0, `in_ready` = 1 immediately. After release, no stale writes appear.
- **Dual enqueue:** ALU (r3, 0x11) and load (r5, 0x22) in the same cycle → next cycle `write0` = 1 with r3/0x11 and `write1` = 1 with r5/0x22. After that edge, `regs[3]` = 0x11, `regs[5]` = 0x22, and `pending` = 0.
- **Same-address ordering:** ALU (r7, 0xAA) and load (r7, 0xBB) together → cycle 1 has `write0` r7/0xAA with `write1` = 0; cycle 2 has `write0` r7/0xBB. The final `regs[7]` = 0xBB.
- **Backpressure:** stall the drain by filling to count 3 (`DEPTH` = 4) → `in_ready` = 0. The held inputs are accepted only once count ≤ 2, and no entry is lost or duplicated.
- **Forwarding:** queue r9 = 0x01 then r9 = 0x02, with `fwd_addr0` = 9 and `fwd_addr1` = 4 → `fwd_hit0` = 1 with data 0x02, `fwd_hit1` = 0 with data 0, and `pending[9]` = 1.
- **Wrap-around:** stream 20 results with distinct addresses and random valids → the register file contents match a reference model, and the pointers wrap without a gap.

Source files
------------

// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg: shared widths, queue depth and entry type for the writeback queue
// Port summary: none (package). WIDTH_SEG/WIDTH_WORD match the register file; WB_DEPTH is the default queue depth.
package wb_queue_pkg;
  localparam int WIDTH_SEG  = 4;
  localparam int WIDTH_WORD = 32;
  localparam int WB_DEPTH   = 4;
  typedef struct packed {
    logic [WIDTH_SEG-1:0]  addr;
    logic [WIDTH_WORD-1:0] data;
  } wb_entry_t;
  function automatic logic [2**WIDTH_SEG-1:0] seg_onehot(input logic [WIDTH_SEG-1:0] a);
    return (2**WIDTH_SEG)'(1) << a;
  endfunction
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: finds the youngest valid queue entry whose address matches a lookup
// Ports: ents/valid (physical slots), head (oldest slot), addr (lookup) -> hit, data (0 when no hit).
module wb_fwd_match import wb_queue_pkg::*; #(
  parameter int DEPTH = WB_DEPTH
) (
  input  wb_entry_t                    ents [DEPTH],
  input  logic [DEPTH-1:0]             valid,
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [WIDTH_SEG-1:0]         addr,
  output logic                         hit,
  output logic [WIDTH_WORD-1:0]        data
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] idx;
  // Walk from oldest to youngest so the last match found wins.
  always_comb begin
    hit = 1'b0;
    data = '0;
    idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && ents[idx].addr == addr) begin
        hit = 1'b1;
        data = ents[idx].data;
      end
    end
  end
endmodule

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback buffer draining up to two results per cycle into the register file
// Ports: clk, rst_n (async active-low); alu_*/mem_* producers; in_ready; write0/waddr0/in0 (oldest),
// write1/waddr1/in1 (second oldest); pending register mask; fwd_addr*/fwd_hit*/fwd_data* bypass lookups.
module wb_queue import wb_queue_pkg::*; #(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid,
  input  logic [WIDTH_SEG-1:0]    alu_addr,
  input  logic [WIDTH_WORD-1:0]   alu_data,
  input  logic                    mem_valid,
  input  logic [WIDTH_SEG-1:0]    mem_addr,
  input  logic [WIDTH_WORD-1:0]   mem_data,
  output logic                    in_ready,
  output logic                    write0,
  output logic [WIDTH_SEG-1:0]    waddr0,
  output logic [WIDTH_WORD-1:0]   in0,
  output logic                    write1,
  output logic [WIDTH_SEG-1:0]    waddr1,
  output logic [WIDTH_WORD-1:0]   in1,
  output logic [2**WIDTH_SEG-1:0] pending,
  input  logic [WIDTH_SEG-1:0]    fwd_addr0,
  input  logic [WIDTH_SEG-1:0]    fwd_addr1,
  output logic                    fwd_hit0,
  output logic                    fwd_hit1,
  output logic [WIDTH_WORD-1:0]   fwd_data0,
  output logic [WIDTH_WORD-1:0]   fwd_data1
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t        ents [DEPTH];
  logic [PW-1:0]    head, tail, head1, tail_m;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] valid;
  logic             push_a, push_m;
  logic [1:0]       push, pop;
  // Readiness is judged from registered count only, so both producers can always land.
  assign in_ready = count <= CW'(DEPTH - 2);
  assign push_a   = alu_valid & in_ready;
  assign push_m   = mem_valid & in_ready;
  assign push     = {1'b0, push_a} + {1'b0, push_m};
  assign tail_m   = push_a ? tail + PW'(1) : tail;
  assign head1    = head + PW'(1);
  assign write0   = count != '0;
  assign waddr0   = ents[head].addr;
  assign in0      = ents[head].data;
  // A same-address pair drains one per cycle so write order never depends on port priority.
  assign write1   = count >= CW'(2) && ents[head1].addr != ents[head].addr;
  assign waddr1   = ents[head1].addr;
  assign in1      = ents[head1].data;
  assign pop      = {1'b0, write0} + {1'b0, write1};
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    assign valid[i] = {1'b0, PW'(i) - head} < count;
  end
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      pending = pending | (valid[i] ? seg_onehot(ents[i].addr) : '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Entry payloads need no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (push_a) ents[tail] <= '{addr: alu_addr, data: alu_data};
    if (push_m) ents[tail_m] <= '{addr: mem_addr, data: mem_data};
  end
  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd0 (
    .ents(ents), .valid(valid), .head(head), .addr(fwd_addr0), .hit(fwd_hit0), .data(fwd_data0)
  );
  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .ents(ents), .valid(valid), .head(head), .addr(fwd_addr1), .hit(fwd_hit1), .data(fwd_data1)
  );
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: randomized and directed checks of wb_queue against a queue-based reference model
module tb_wb_queue;
  import wb_queue_pkg::*;
  localparam int NR = 2**WIDTH_SEG;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic [WIDTH_SEG-1:0] alu_addr = '0, mem_addr = '0, fwd_addr0 = '0, fwd_addr1 = '0;
  logic [WIDTH_WORD-1:0] alu_data = '0, mem_data = '0;
  logic in_ready, write0, write1, fwd_hit0, fwd_hit1;
  logic [WIDTH_SEG-1:0] waddr0, waddr1;
  logic [WIDTH_WORD-1:0] in0, in1, fwd_data0, fwd_data1;
  logic [NR-1:0] pending;
  typedef struct {
    logic [WIDTH_SEG-1:0] a;
    logic [WIDTH_WORD-1:0] d;
  } ment_t;
  ment_t q[$];
  logic [WIDTH_WORD-1:0] mregs [NR];
  logic [WIDTH_WORD-1:0] dregs [NR];
  int vec = 0, bad = 0;
  wb_queue dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .in_ready(in_ready),
    .write0(write0), .waddr0(waddr0), .in0(in0),
    .write1(write1), .waddr1(waddr1), .in1(in1),
    .pending(pending),
    .fwd_addr0(fwd_addr0), .fwd_addr1(fwd_addr1),
    .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic lookup(input logic [WIDTH_SEG-1:0] a, output logic h, output logic [WIDTH_WORD-1:0] d);
    h = 1'b0;
    d = '0;
    foreach (q[i]) if (q[i].a == a) begin h = 1'b1; d = q[i].d; end
  endtask
  task automatic check_outs;
    int n;
    logic w1, h;
    logic [WIDTH_WORD-1:0] d;
    logic [NR-1:0] pm;
    n = q.size();
    chk("in_ready", in_ready, 64'(WB_DEPTH - n >= 2));
    chk("write0", write0, 64'(n >= 1));
    if (n >= 1) begin
      chk("waddr0", waddr0, q[0].a);
      chk("in0", in0, q[0].d);
    end
    w1 = n >= 2 && q[1].a != q[0].a;
    chk("write1", write1, w1);
    if (w1) begin
      chk("waddr1", waddr1, q[1].a);
      chk("in1", in1, q[1].d);
    end
    pm = '0;
    foreach (q[i]) pm[q[i].a] = 1'b1;
    chk("pending", pending, pm);
    lookup(fwd_addr0, h, d);
    chk("fwd_hit0", fwd_hit0, h);
    chk("fwd_data0", fwd_data0, d);
    lookup(fwd_addr1, h, d);
    chk("fwd_hit1", fwd_hit1, h);
    chk("fwd_data1", fwd_data1, d);
  endtask
  task automatic step(input logic av, input logic [WIDTH_SEG-1:0] aa, input logic [WIDTH_WORD-1:0] ad,
                      input logic mv, input logic [WIDTH_SEG-1:0] ma, input logic [WIDTH_WORD-1:0] md,
                      input logic [WIDTH_SEG-1:0] f0, input logic [WIDTH_SEG-1:0] f1, output logic acc);
    int n;
    logic two;
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    fwd_addr0 = f0; fwd_addr1 = f1;
    #1;
    check_outs();
    if (write0) dregs[waddr0] = in0;
    if (write1) dregs[waddr1] = in1;
    n = q.size();
    acc = WB_DEPTH - n >= 2;
    two = n >= 2 && q[1].a != q[0].a;
    if (n >= 1) begin mregs[q[0].a] = q[0].d; void'(q.pop_front()); end
    if (two) begin mregs[q[0].a] = q[0].d; void'(q.pop_front()); end
    if (acc && av) q.push_back('{a: aa, d: ad});
    if (acc && mv) q.push_back('{a: ma, d: md});
    @(posedge clk);
  endtask
  task automatic idle(input int k);
    logic acc;
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 4'd9, 4'd4, acc);
  endtask
  initial begin
    logic acc;
    logic av, mv;
    logic [WIDTH_SEG-1:0] aa, ma;
    logic [WIDTH_WORD-1:0] ad, md;
    for (int i = 0; i < NR; i++) begin mregs[i] = '0; dregs[i] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    // dual enqueue, distinct addresses
    step(1, 4'd3, 32'h11, 1, 4'd5, 32'h22, 4'd3, 4'd5, acc);
    idle(1);
    chk("regs3", dregs[3], 32'h11);
    chk("regs5", dregs[5], 32'h22);
    #2 chk("pend_empty", pending, '0);
    // same-address pair drains one per cycle
    step(1, 4'd7, 32'hAA, 1, 4'd7, 32'hBB, 4'd7, 4'd0, acc);
    idle(1);
    chk("regs7_mid", dregs[7], 32'hAA);
    idle(1);
    chk("regs7", dregs[7], 32'hBB);
    // forwarding picks the youngest of two r9 entries
    step(1, 4'd9, 32'h01, 1, 4'd9, 32'h02, 4'd9, 4'd4, acc);
    #2;
    chk("fwd_hit0_r9", fwd_hit0, 1'b1);
    chk("fwd_data0_r9", fwd_data0, 32'h02);
    chk("fwd_hit1_r4", fwd_hit1, 1'b0);
    chk("fwd_data1_r4", fwd_data1, 32'h0);
    chk("pending9", pending[9], 1'b1);
    idle(2);
    // backpressure: same-address pairs build the queue up to 3
    for (int p = 0; p < 4; p++) begin
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++)
        step(1, 4'd2, 32'h100 + 32'(2*p), 1, 4'd2, 32'h101 + 32'(2*p), 4'd2, 4'd1, acc);
      chk("bp_accept", acc, 1'b1);
    end
    #2 chk("bp_full", in_ready, 1'b0);
    chk("bp_count", 64'(q.size()), 64'd3);
    // reset mid-stream with three queued entries
    alu_valid = 1'b0; mem_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_write0", write0, 1'b0);
    chk("rst_write1", write1, 1'b0);
    chk("rst_pending", pending, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_fwd_hit0", fwd_hit0, 1'b0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    idle(3);
    // random stream with held producer values until accepted
    av = 0; mv = 0; aa = 0; ma = 0; ad = 0; md = 0; acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (acc || !av) begin
        av = 1'($urandom_range(0, 1));
        aa = WIDTH_SEG'($urandom_range(0, NR - 1));
        ad = $urandom;
      end
      if (acc || !mv) begin
        mv = 1'($urandom_range(0, 1));
        ma = WIDTH_SEG'($urandom_range(0, NR - 1));
        md = $urandom;
      end
      step(av, aa, ad, mv, ma, md, WIDTH_SEG'($urandom_range(0, NR - 1)), WIDTH_SEG'($urandom_range(0, NR - 1)), acc);
    end
    idle(6);
    for (int i = 0; i < NR; i++) chk("regfile", dregs[i], mregs[i]);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
